// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, registers the zero-latency ROM word into a one-entry
// output stage toward decode, handles branch redirects and HALT. Optional macro FETCH_COUNT_EN adds o_fetch_count.
module instr_fetch_ctrl #(
  parameter int                      NB_INSTRUCTION = 16,
  parameter int                      NB_ADDR        = 10,
  parameter int                      NB_OPCODE      = 5,
  parameter logic [NB_OPCODE-1:0]    HALT_OPCODE    = 5'b00000,
  parameter logic [NB_ADDR-1:0]      START_ADDR     = '0
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  output logic [NB_ADDR-1:0]         o_rom_addr,
  input  logic [NB_INSTRUCTION-1:0]  i_rom_data,
  output logic [NB_INSTRUCTION-1:0]  o_instr,
  output logic [NB_ADDR-1:0]         o_pc,
  output logic                       o_instr_valid,
  input  logic                       i_instr_ready,
  input  logic                       i_branch_valid,
  input  logic [NB_ADDR-1:0]         i_branch_addr,
  output logic                       o_busy,
  output logic                       o_halted,
`ifdef FETCH_COUNT_EN
  output logic [15:0]                o_fetch_count,
`endif
  output logic [1:0]                 o_state
);

  // Handshake: a word moves to decode on a rising edge where o_instr_valid && i_instr_ready;
  // o_instr/o_pc must not change while valid is high and ready is low.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_t;

  state_t                      state_q, state_d;
  logic [NB_ADDR-1:0]          fetch_pc_q;
  logic [NB_INSTRUCTION-1:0]   instr_q;
  logic [NB_ADDR-1:0]          pc_q;
  logic                        valid_q;

  logic accept;
  logic halt_op;
  logic load;
  logic restart;
  logic branch_take;
  logic drop;

  assign accept  = valid_q && i_instr_ready;
  assign halt_op = (i_rom_data[NB_INSTRUCTION-1 -: NB_OPCODE] == HALT_OPCODE);

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath strobes; branch outranks load, accept and HALT detect
  always_comb begin
    state_d     = state_q;
    load        = 1'b0;
    restart     = 1'b0;
    branch_take = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          restart = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (i_branch_valid) begin
          branch_take = 1'b1;
        end else if (!valid_q || accept) begin
          load = 1'b1;
          if (halt_op) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (i_branch_valid) begin
          branch_take = 1'b1;
          state_d     = RUN;
        end else if (accept) begin
          drop    = 1'b1;
          state_d = HALT;
        end
      end
      HALT: begin
        if (i_start) begin
          restart = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from state
  always_comb begin
    o_busy   = (state_q == RUN) || (state_q == DRAIN);
    o_halted = (state_q == HALT);
    o_state  = state_q;
  end

  // Fetch PC is held on a HALT load so o_rom_addr stays on the HALT word
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc_q <= START_ADDR;
    end else if (restart) begin
      fetch_pc_q <= START_ADDR;
    end else if (branch_take) begin
      fetch_pc_q <= i_branch_addr;
    end else if (load && !halt_op) begin
      fetch_pc_q <= fetch_pc_q + NB_ADDR'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      instr_q <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      if (load) begin
        instr_q <= i_rom_data;
        pc_q    <= fetch_pc_q;
      end
      if (branch_take || drop) valid_q <= 1'b0;
      else if (load)           valid_q <= 1'b1;
    end
  end

  assign o_rom_addr    = fetch_pc_q;
  assign o_instr       = instr_q;
  assign o_pc          = pc_q;
  assign o_instr_valid = valid_q;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q;

  // A word flushed by a branch is not delivered, so it is not counted
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      fetch_count_q <= '0;
    end else if (restart) begin
      fetch_count_q <= '0;
    end else if (accept && !branch_take && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign o_fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: sequential fetch to HALT, back-pressure, branch, DRAIN redirect,
// async reset and PC wrap (second instance with START_ADDR = 0x3FE). Honours FETCH_COUNT_EN.
module tb_instr_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic        ready;
  logic        br_valid;
  logic [9:0]  br_addr;

  logic [9:0]  rom_addr, pc;
  logic [15:0] rom_data, instr;
  logic        valid, busy, halted;
  logic [1:0]  state;

  logic [9:0]  hi_rom_addr, hi_pc;
  logic [15:0] hi_rom_data, hi_instr;
  logic        hi_valid, hi_busy, hi_halted;
  logic [1:0]  hi_state;

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count, hi_fetch_count;
`endif

  logic [15:0] rom [1024];

  int n_cmp = 0;
  int n_err = 0;

  assign rom_data    = rom[rom_addr];
  assign hi_rom_data = rom[hi_rom_addr];

  instr_fetch_ctrl u_dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .o_rom_addr     (rom_addr),
    .i_rom_data     (rom_data),
    .o_instr        (instr),
    .o_pc           (pc),
    .o_instr_valid  (valid),
    .i_instr_ready  (ready),
    .i_branch_valid (br_valid),
    .i_branch_addr  (br_addr),
    .o_busy         (busy),
    .o_halted       (halted),
`ifdef FETCH_COUNT_EN
    .o_fetch_count  (fetch_count),
`endif
    .o_state        (state)
  );

  instr_fetch_ctrl #(.START_ADDR(10'h3FE)) u_dut_hi (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_start        (start),
    .o_rom_addr     (hi_rom_addr),
    .i_rom_data     (hi_rom_data),
    .o_instr        (hi_instr),
    .o_pc           (hi_pc),
    .o_instr_valid  (hi_valid),
    .i_instr_ready  (ready),
    .i_branch_valid (br_valid),
    .i_branch_addr  (br_addr),
    .o_busy         (hi_busy),
    .o_halted       (hi_halted),
`ifdef FETCH_COUNT_EN
    .o_fetch_count  (hi_fetch_count),
`endif
    .o_state        (hi_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [9:0] exp_pc);
    check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    check_eq({tag, "_pc"},    32'(pc),    32'(exp_pc));
    check_eq({tag, "_instr"}, 32'(instr), 32'(rom[exp_pc]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"},  32'(valid),    32'd0);
    check_eq({tag, "_pc"},     32'(pc),       32'd0);
    check_eq({tag, "_instr"},  32'(instr),    32'd0);
    check_eq({tag, "_addr"},   32'(rom_addr), 32'd0);
    check_eq({tag, "_busy"},   32'(busy),     32'd0);
    check_eq({tag, "_halted"}, 32'(halted),   32'd0);
`ifdef FETCH_COUNT_EN
    check_eq({tag, "_count"},  32'(fetch_count), 32'd0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) rom[i] = 16'h8000 | 16'(i);
    rom[4]     = 16'h0004;  // HALT opcode (bits 15:11 == 0)
    rst = 1'b1; start = 1'b0; ready = 1'b0; br_valid = 1'b0; br_addr = '0;
    step();
    step();
    check_reset_outputs("rst");
    check_eq("rst_state", 32'(state), 32'd0);
    rst = 1'b0;

    // Sequential fetch 0..4, HALT at 4
    start = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b1;
    check_eq("start_addr", 32'(rom_addr), 32'd0);
    check_eq("start_valid", 32'(valid), 32'd0);
    check_eq("start_busy", 32'(busy), 32'd1);
    for (int k = 0; k <= 4; k++) begin
      step();
      check_word($sformatf("seq%0d", k), 10'(k));
    end
    check_eq("drain_addr", 32'(rom_addr), 32'd4);
    check_eq("drain_state", 32'(state), 32'd2);
    check_eq("drain_halted", 32'(halted), 32'd0);
    step();
    check_eq("halt_halted", 32'(halted), 32'd1);
    check_eq("halt_busy", 32'(busy), 32'd0);
    check_eq("halt_valid", 32'(valid), 32'd0);
    check_eq("halt_addr", 32'(rom_addr), 32'd4);
`ifdef FETCH_COUNT_EN
    check_eq("halt_count", 32'(fetch_count), 32'd5);
`endif
    step();
    check_eq("halt_hold", 32'(rom_addr), 32'd4);

    // Restart from HALT; o_pc/o_instr hold until the first new load
    rom[4] = 16'h8004;
    ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("restart_state", 32'(state), 32'd1);
    check_eq("restart_addr", 32'(rom_addr), 32'd0);
    check_eq("restart_pc_hold", 32'(pc), 32'd4);
    check_eq("restart_halted", 32'(halted), 32'd0);
`ifdef FETCH_COUNT_EN
    check_eq("restart_count", 32'(fetch_count), 32'd0);
`endif
    step();
    check_word("rs0", 10'd0);
    ready = 1'b1;
    step();
    check_word("rs1", 10'd1);
    step();
    check_word("rs2", 10'd2);

    // Back-pressure for 3 cycles at pc 2
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_word($sformatf("bp%0d", k), 10'd2);
      check_eq($sformatf("bp%0d_addr", k), 32'(rom_addr), 32'd3);
    end
    ready = 1'b1;
    step();
    check_word("bp_resume", 10'd3);
    step();
    check_word("rs4", 10'd4);
    step();
    check_word("rs5", 10'd5);

    // Branch to 0x200 while pc 5 valid and ready high: word 5 flushed
    br_valid = 1'b1;
    br_addr  = 10'h200;
    step();
    br_valid = 1'b0;
    check_eq("br_bubble_valid", 32'(valid), 32'd0);
    check_eq("br_addr", 32'(rom_addr), 32'h200);
    step();
    check_word("br_t0", 10'h200);
    step();
    check_word("br_t1", 10'h201);
`ifdef FETCH_COUNT_EN
    check_eq("br_count", 32'(fetch_count), 32'd6);
`endif

    // HALT at 0x202, held in DRAIN, redirected to 0x010
    rom[10'h202] = 16'h0202;
    step();
    check_word("dr_halt", 10'h202);
    check_eq("dr_state", 32'(state), 32'd2);
    check_eq("dr_addr", 32'(rom_addr), 32'h202);
    ready    = 1'b0;
    br_valid = 1'b1;
    br_addr  = 10'h010;
    step();
    br_valid = 1'b0;
    check_eq("dr_flush_valid", 32'(valid), 32'd0);
    check_eq("dr_flush_state", 32'(state), 32'd1);
    check_eq("dr_flush_halted", 32'(halted), 32'd0);
    check_eq("dr_flush_addr", 32'(rom_addr), 32'h010);
    ready = 1'b1;
    step();
    check_word("dr_t0", 10'h010);
    check_eq("dr_t0_halted", 32'(halted), 32'd0);

    // Async reset mid-stream at pc 7
    br_valid = 1'b1;
    br_addr  = 10'h007;
    step();
    br_valid = 1'b0;
    step();
    check_word("pre_rst", 10'h007);
    rst = 1'b1;
    #2;
    check_reset_outputs("async_rst");
    check_eq("async_rst_state", 32'(state), 32'd0);
    step();
    rst = 1'b0;

    // Wrap: START_ADDR = 0x3FE instance
    check_eq("hi_rst_addr", 32'(hi_rom_addr), 32'h3FE);
    start = 1'b1;
    step();
    start = 1'b0;
    ready = 1'b1;
    check_eq("hi_start_addr", 32'(hi_rom_addr), 32'h3FE);
    step();
    check_eq("hi_pc0", 32'(hi_pc), 32'h3FE);
    check_eq("hi_instr0", 32'(hi_instr), 32'h83FE);
    step();
    check_eq("hi_pc1", 32'(hi_pc), 32'h3FF);
    step();
    check_eq("hi_pc2", 32'(hi_pc), 32'h000);
    check_eq("hi_instr2", 32'(hi_instr), 32'h8000);
    check_eq("hi_valid", 32'(hi_valid), 32'd1);
    check_eq("hi_addr_wrap", 32'(hi_rom_addr), 32'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction fetch sequencer for the processor's program ROM. Owns the program counter and drives the ROM read address. Registers the combinational ROM word into a one-entry output stage with a valid/ready handshake toward decode. Handles branch redirects and stops cleanly on a HALT opcode.

## Interface
- NB_INSTRUCTION, 16, instruction width; matches program ROM word.
- NB_ADDR, 10, program address width; matches program ROM depth 2**NB_ADDR.
- NB_OPCODE, 5, opcode field width, taken from instruction bits [NB_INSTRUCTION-1 -: NB_OPCODE].
- HALT_OPCODE, 5'b00000, opcode value that terminates fetching.
- START_ADDR, 0, first fetch address after i_start.
- i_clock  in  1  single clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  start request; sampled in IDLE and HALT only.
- o_rom_addr  out  NB_ADDR  ROM read address (= fetch PC, registered).
- i_rom_data  in  NB_INSTRUCTION  ROM word at o_rom_addr, same cycle (zero-latency ROM).
- o_instr  out  NB_INSTRUCTION  fetched instruction.
- o_pc  out  NB_ADDR  address o_instr was fetched from.
- o_instr_valid  out  1  o_instr/o_pc valid.
- i_instr_ready  in  1  decode accepts when valid && ready at a rising edge.
- i_branch_valid  in  1  redirect request, one-cycle pulse.
- i_branch_addr  in  NB_ADDR  redirect target.
- o_busy  out  1  state is RUN or DRAIN.
- o_halted  out  1  state is HALT.

## Operation
- States: IDLE, RUN, DRAIN, HALT. Reset enters IDLE.
- Reset values: fetch PC = START_ADDR, o_instr = 0, o_pc = 0, o_instr_valid = 0, o_busy = 0, o_halted = 0.
- IDLE: i_start -> fetch PC <= START_ADDR, go to RUN. Other inputs are ignored.
- RUN: the output stage loads when empty or when the held word is accepted this edge.
  - Load: o_instr <= i_rom_data, o_pc <= fetch PC, valid <= 1, fetch PC <= fetch PC + 1 (mod 2**NB_ADDR; 2**NB_ADDR-1 wraps to 0).
  - Accept with no load possible cannot occur in RUN, because accept always frees the stage. In DRAIN/HALT, accept clears valid.
- HALT detect: if the loaded word's opcode == HALT_OPCODE, go to DRAIN. Fetch PC is not incremented on that load. No further loads occur.
- DRAIN: the HALT word is held until accepted, then valid <= 0 and go to HALT.
- HALT: fetch PC frozen. i_start -> fetch PC <= START_ADDR, o_pc/o_instr hold, go to RUN.
- Branch (RUN or DRAIN): fetch PC <= i_branch_addr, valid <= 0 (flush held word even if ready is high), state <= RUN. Branch has priority over load, accept and HALT detect in the same cycle. Branch in IDLE/HALT is ignored.
- i_start in RUN/DRAIN is ignored.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). An in-flight word is discarded.

## Timing
- o_rom_addr is a register output. The ROM path is combinational; o_instr is captured at the edge.
- Start sampled at edge t -> o_rom_addr = START_ADDR after t -> o_instr_valid = 1 after edge t+1.
- Throughput: one instruction per cycle with i_instr_ready held high.
- Back-pressure: while valid && !ready, o_instr, o_pc, o_rom_addr are stable.
- Branch sampled at edge b -> valid = 0 after b -> first target word valid after b+1 (one bubble).
- o_halted rises on the edge where the HALT word is accepted. o_busy falls on the same edge.

## Configuration
- FETCH_COUNT_EN defined: adds output o_fetch_count (16 bits).
  - Increments on each accepted instruction, HALT word included.
  - Saturates at 16'hFFFF.
  - Cleared by reset and by an accepted i_start.
- FETCH_COUNT_EN undefined: the port and counter do not exist; all other behaviour is identical.

## Test plan
- Reset, i_start pulse, ready=1, ROM[0..3] = non-HALT, ROM[4] = HALT -> o_pc sequence 0,1,2,3,4 on consecutive cycles; o_halted = 1 one edge after PC 4 is accepted; o_rom_addr stays 4.
- Ready low for 3 cycles while o_pc = 2 -> o_instr/o_pc hold at ROM[2]/2 and o_rom_addr holds 3; after ready returns, next o_pc = 3 with no skipped or duplicated word.
- Branch to 0x200 while o_pc = 5 is valid with ready=1 -> word at 5 is not delivered, one invalid cycle, next o_pc = 0x200, then 0x201.
- START_ADDR = 0x3FE, ROM[0x3FE], ROM[0x3FF], ROM[0] non-HALT -> o_pc = 0x3FE, 0x3FF, 0x000 (wrap).
- HALT word held in DRAIN with ready=0 and branch to 0x010 asserted -> HALT flushed, state RUN, next o_pc = 0x010, o_halted stays 0. Separately, i_start in HALT -> restart at START_ADDR.
- Reset asserted mid-stream at o_pc = 7 -> all outputs return to reset values immediately, without waiting for a clock edge. With FETCH_COUNT_EN, o_fetch_count reads 0 after reset and 5 after the first scenario (HALT word included).
